// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// The MC_JAL_EN macro adds the JALWB state to the state encoding.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BR     = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
`ifdef MC_JAL_EN
    , S_JALWB = 4'd13
`endif
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_BUS     = 2'd2
  } cause_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_EXC = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/mc_control_fsm_watchdog.sv
// Memory stall watchdog: counts stalled cycles in a memory phase and
// pulses timeout once the count reaches MEM_TIMEOUT (0 disables it).
module mc_mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_phase,
  input  logic mem_ready,
  input  logic state_change,
  output logic timeout
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt;
  logic          stalled;

  assign stalled = mem_phase && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && stalled && (cnt == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (state_change) begin
      cnt <= '0;
    end else if (stalled && (MEM_TIMEOUT != 0) && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath with memory stall
// handshake, watchdog and trap handling. Define MC_JAL_EN to enable JAL.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] OPCode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       ExtOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       BranchNe,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       bus_err
);

  state_t state, state_next;
  cause_t cause;
  logic   mem_phase;
  logic   timeout;

  assign mem_phase = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  mc_mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_phase    (mem_phase),
    .mem_ready    (mem_ready),
    .state_change (state_next != state),
    .timeout      (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause <= CAUSE_NONE;
    end else if ((state_next == S_TRAP) && (state != S_TRAP)) begin
      cause <= timeout ? CAUSE_BUS : CAUSE_ILLEGAL;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_next = S_DECODE;
        else if (timeout) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (OPCode)
          OP_LW, OP_SW:               state_next = S_MEMADR;
          OP_RT:                      state_next = S_EXE;
          OP_BEQ, OP_BNE:             state_next = S_BR;
          OP_ADDI, OP_ANDI, OP_ORI:   state_next = S_IEX;
          OP_J:                       state_next = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:                     state_next = S_JALWB;
`endif
          default: state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (OPCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_TRAP;
      end
      S_MEMWR: begin
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_EXE:   state_next = S_ALUWB;
      S_IEX:   state_next = S_IWB;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ExtOp      = 1'b0;
    RegDst     = REGDST_RT;
    MemtoReg   = MEMTOREG_ALU;
    PCSrc      = PCSRC_ALU;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALU_ADD;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    RegWrite   = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB = SRCB_FOUR;
        mem_req = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_BOFF;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = MEMTOREG_MDR;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        mem_req  = 1'b1;
        // The write is withdrawn in the cycle the watchdog fires.
        MemWrite = !timeout;
      end
      S_EXE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = REGDST_RD;
        RegWrite = 1'b1;
      end
      S_BR: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSrc    = PCSRC_BR;
        Branch   = (OPCode == OP_BEQ);
        BranchNe = (OPCode == OP_BNE);
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (OPCode)
          OP_ANDI: begin ALUOp = ALU_AND; ExtOp = 1'b1; end
          OP_ORI:  begin ALUOp = ALU_OR;  ExtOp = 1'b1; end
          default: begin ALUOp = ALU_ADD; ExtOp = 1'b0; end
        endcase
      end
      S_IWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JMP;
        PCWrite = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JALWB: begin
        PCSrc    = PCSRC_JMP;
        PCWrite  = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = MEMTOREG_PC;
        RegWrite = 1'b1;
      end
`endif
      S_TRAP: begin
        PCSrc      = PCSRC_EXC;
        PCWrite    = 1'b1;
        illegal_op = (cause == CAUSE_ILLEGAL);
        bus_err    = (cause == CAUSE_BUS);
      end
      default: ;
    endcase
    // Reset holds FETCH, so its request and enables must be masked here.
    if (!reset_n) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      BranchNe = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected output vectors
// are queued by the stimulus and compared by an independent monitor.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] OPCode = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       mem_req, IorD, ALUSrcA, ExtOp;
  logic [1:0] RegDst, MemtoReg, PCSrc, ALUSrcB;
  logic [2:0] ALUOp;
  logic       IRWrite, MemWrite, PCWrite, Branch, BranchNe, RegWrite;
  logic       illegal_op, bus_err;

  typedef struct packed {
    logic       mem_req;
    logic       IorD;
    logic       ALUSrcA;
    logic       ExtOp;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] PCSrc;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       IRWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       Branch;
    logic       BranchNe;
    logic       RegWrite;
    logic       illegal_op;
    logic       bus_err;
  } outs_t;

  typedef struct {
    string nm;
    outs_t v;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  outs_t got;

  assign got = {mem_req, IorD, ALUSrcA, ExtOp, RegDst, MemtoReg, PCSrc, ALUSrcB,
                ALUOp, IRWrite, MemWrite, PCWrite, Branch, BranchNe, RegWrite,
                illegal_op, bus_err};

  mc_control_fsm #(
    .MEM_TIMEOUT     (4),
    .TRAP_ON_ILLEGAL (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .OPCode     (OPCode),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .IorD       (IorD),
    .ALUSrcA    (ALUSrcA),
    .ExtOp      (ExtOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .BranchNe   (BranchNe),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  function automatic outs_t o_fetch(input logic mr);
    outs_t o = '0;
    o.ALUSrcB = 2'b01; o.mem_req = 1'b1; o.IRWrite = mr; o.PCWrite = mr;
    return o;
  endfunction
  function automatic outs_t o_reset();
    outs_t o = '0;
    o.ALUSrcB = 2'b01;
    return o;
  endfunction
  function automatic outs_t o_decode();
    outs_t o = '0; o.ALUSrcB = 2'b11; return o;
  endfunction
  function automatic outs_t o_memadr();
    outs_t o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; return o;
  endfunction
  function automatic outs_t o_memrd();
    outs_t o = '0; o.IorD = 1'b1; o.mem_req = 1'b1; return o;
  endfunction
  function automatic outs_t o_memwb();
    outs_t o = '0; o.MemtoReg = 2'b01; o.RegWrite = 1'b1; return o;
  endfunction
  function automatic outs_t o_memwr();
    outs_t o = '0; o.IorD = 1'b1; o.mem_req = 1'b1; o.MemWrite = 1'b1; return o;
  endfunction
  function automatic outs_t o_exe();
    outs_t o = '0; o.ALUSrcA = 1'b1; o.ALUOp = 3'b010; return o;
  endfunction
  function automatic outs_t o_aluwb();
    outs_t o = '0; o.RegDst = 2'b01; o.RegWrite = 1'b1; return o;
  endfunction
  function automatic outs_t o_br(input logic bne);
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUOp = 3'b001; o.PCSrc = 2'b01;
    o.Branch = !bne; o.BranchNe = bne;
    return o;
  endfunction
  function automatic outs_t o_iex(input logic [2:0] op, input logic ext);
    outs_t o = '0;
    o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = op; o.ExtOp = ext;
    return o;
  endfunction
  function automatic outs_t o_iwb();
    outs_t o = '0; o.RegWrite = 1'b1; return o;
  endfunction
  function automatic outs_t o_jump();
    outs_t o = '0; o.PCSrc = 2'b10; o.PCWrite = 1'b1; return o;
  endfunction
  function automatic outs_t o_jalwb();
    outs_t o = '0;
    o.PCSrc = 2'b10; o.PCWrite = 1'b1; o.RegDst = 2'b10; o.MemtoReg = 2'b10;
    o.RegWrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_trap(input logic ill, input logic bus);
    outs_t o = '0;
    o.PCSrc = 2'b11; o.PCWrite = 1'b1; o.illegal_op = ill; o.bus_err = bus;
    return o;
  endfunction

  // One clock cycle: drive mem_ready just after the edge and queue the
  // outputs expected for the state entered at that edge.
  task automatic step(input logic mr, input outs_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    mem_ready = mr;
    x.nm = nm;
    x.v  = e;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (got !== x.v) begin
          errors++;
          $display("FAIL %s: got %h required %h", x.nm, got, x.v);
        end
      end
    end
  end

  initial begin : watchdog_guard
    #200000;
    $display("FAIL sim_timeout: got running required finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    step(1'b1, o_reset(), "reset_state");
    step(1'b1, o_fetch(1'b1), "lw_fetch"); reset_n = 1'b1; OPCode = 6'b100011;
    step(1'b1, o_decode(), "lw_decode");
    step(1'b1, o_memadr(), "lw_memadr");
    step(1'b1, o_memrd(), "lw_memrd");
    step(1'b1, o_memwb(), "lw_memwb");

    step(1'b1, o_fetch(1'b1), "sw_fetch"); OPCode = 6'b101011;
    step(1'b1, o_decode(), "sw_decode");
    step(1'b1, o_memadr(), "sw_memadr");
    step(1'b1, o_memwr(), "sw_memwr");

    step(1'b1, o_fetch(1'b1), "ori_fetch"); OPCode = 6'b001101;
    step(1'b1, o_decode(), "ori_decode");
    step(1'b1, o_iex(3'b100, 1'b1), "ori_iex");
    step(1'b1, o_iwb(), "ori_iwb");
    step(1'b1, o_fetch(1'b1), "andi_fetch"); OPCode = 6'b001100;
    step(1'b1, o_decode(), "andi_decode");
    step(1'b1, o_iex(3'b011, 1'b1), "andi_iex");
    step(1'b1, o_iwb(), "andi_iwb");
    step(1'b1, o_fetch(1'b1), "addi_fetch"); OPCode = 6'b001000;
    step(1'b1, o_decode(), "addi_decode");
    step(1'b1, o_iex(3'b000, 1'b0), "addi_iex");
    step(1'b1, o_iwb(), "addi_iwb");

    step(1'b1, o_fetch(1'b1), "bne_fetch"); OPCode = 6'b000101;
    step(1'b1, o_decode(), "bne_decode");
    step(1'b1, o_br(1'b1), "bne_br");
    step(1'b1, o_fetch(1'b1), "beq_fetch"); OPCode = 6'b000100;
    step(1'b1, o_decode(), "beq_decode");
    step(1'b1, o_br(1'b0), "beq_br");

    step(1'b1, o_fetch(1'b1), "rt_fetch"); OPCode = 6'b000000;
    step(1'b1, o_decode(), "rt_decode");
    step(1'b1, o_exe(), "rt_exe");
    step(1'b1, o_aluwb(), "rt_aluwb");

    step(1'b0, o_fetch(1'b0), "stall_1"); OPCode = 6'b000010;
    step(1'b0, o_fetch(1'b0), "stall_2");
    step(1'b0, o_fetch(1'b0), "stall_3");
    step(1'b1, o_fetch(1'b1), "stall_release");
    step(1'b1, o_decode(), "j_decode");
    step(1'b1, o_jump(), "j_jump");

    step(1'b1, o_fetch(1'b1), "to_fetch"); OPCode = 6'b100011;
    step(1'b1, o_decode(), "to_decode");
    step(1'b1, o_memadr(), "to_memadr");
    for (int i = 0; i < 5; i++) step(1'b0, o_memrd(), "to_memrd_stall");
    step(1'b0, o_trap(1'b0, 1'b1), "to_trap_bus");

    step(1'b1, o_fetch(1'b1), "ill_fetch"); OPCode = 6'b111111;
    step(1'b1, o_decode(), "ill_decode");
    step(1'b1, o_trap(1'b1, 1'b0), "ill_trap");

    step(1'b1, o_fetch(1'b1), "jal_fetch"); OPCode = 6'b000011;
    step(1'b1, o_decode(), "jal_decode");
`ifdef MC_JAL_EN
    step(1'b1, o_jalwb(), "jal_jalwb");
`else
    step(1'b1, o_trap(1'b1, 1'b0), "jal_trap");
`endif

    step(1'b1, o_fetch(1'b1), "rst_sw_fetch"); OPCode = 6'b101011;
    step(1'b1, o_decode(), "rst_sw_decode");
    step(1'b1, o_memadr(), "rst_sw_memadr");
    step(1'b0, o_memwr(), "rst_sw_memwr");
    step(1'b0, o_reset(), "rst_mid_memwr"); reset_n = 1'b0;
    step(1'b1, o_fetch(1'b1), "post_rst_fetch"); reset_n = 1'b1; OPCode = 6'b000010;
    step(1'b1, o_decode(), "post_rst_decode");
    step(1'b1, o_jump(), "post_rst_jump");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
